// File: rtl/inst_fetch_ctrl_if.sv
// ROM read port and decode-side handshake of the fetch sequencer.
// master = fetch controller, slave = ROM/decode side.
interface inst_fetch_ctrl_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output rom_addr, out_valid, out_inst, out_pc,
    input  rom_inst, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_inst, out_pc,
    output rom_inst, out_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the instruction ROM and queues
// {pc, inst} words into a prefetch FIFO that drains to decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | fetch disabled (en may rise and fetch in the same cycle)
// S_RUN    | fetching one word per cycle while the FIFO has room
// S_HALTED | halt opcode queued; no fetches until a redirect
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF,
  localparam int         CW        = $clog2(DEPTH + 1),
  localparam int         PW        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  inst_fetch_ctrl_if.master   bus,
  output logic [CW-1:0]       fifo_count,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    fetch_pc_q;
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    mem_pc   [DEPTH];
  logic [31:0]    mem_inst [DEPTH];

  logic valid;
  logic full;
  logic pop;
  logic fetch;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = valid & bus.out_ready;
  // A pop in the same cycle frees the slot the new word lands in.
  assign fetch = en & ~redirect_valid & (state_q != S_HALTED) & (~full | pop);

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = en ? S_RUN : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (fetch && (bus.rom_inst == HALT_INST)) state_d = S_HALTED;
          else if (en)                              state_d = S_RUN;
          else                                      state_d = S_IDLE;
        end
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC & ~32'd3;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc & ~32'd3;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        if (fetch) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
          tail_q     <= tail_q + PW'(1);
        end
        if (pop) head_q <= head_q + PW'(1);
        if (fetch && !pop)      count_q <= count_q + CW'(1);
        else if (!fetch && pop) count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (fetch) begin
      mem_pc[tail_q]   <= fetch_pc_q;
      mem_inst[tail_q] <= bus.rom_inst;
    end
  end

  assign bus.rom_addr  = {2'b00, fetch_pc_q[31:2]};
  assign bus.out_valid = valid;
  assign bus.out_inst  = mem_inst[head_q];
  assign bus.out_pc    = mem_pc[head_q];
  assign fifo_count    = count_q;
  assign halted        = (state_q == S_HALTED);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed stimulus pushes expected
// {pc, inst} pairs; monitors pop and compare on every accepted head.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  fifo_count;
  logic        halted;
  logic        en_w = 1'b0;
  logic [1:0]  fifo_count_w;
  logic        halted_w;
  logic        halt_mode = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_qw[$];

  always #5 clk = ~clk;

  inst_fetch_ctrl_if ifc ();
  inst_fetch_ctrl_if ifw ();

  function automatic logic [31:0] rom_word(input logic [31:0] a, input logic hm);
    if (hm && a == 32'd2) return 32'hFFFF_FFFF;
    return {16'hC0DE, a[13:0], 2'b00};
  endfunction

  assign ifc.rom_inst = rom_word(ifc.rom_addr, halt_mode);
  assign ifw.rom_inst = rom_word(ifw.rom_addr, 1'b0);

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2), .HALT_INST(32'hFFFF_FFFF)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(ifc), .fifo_count(fifo_count), .halted(halted)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .HALT_INST(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en_w), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .bus(ifw), .fifo_count(fifo_count_w), .halted(halted_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", ifc.out_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_pc", ifc.out_pc, e[63:32]);
        chk("out_inst", ifc.out_inst, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifw.out_valid && ifw.out_ready) begin
      if (exp_qw.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop_wrap actual_pc=%h expected=none", ifw.out_pc);
      end else begin
        logic [63:0] e;
        e = exp_qw.pop_front();
        chk("wrap_out_pc", ifw.out_pc, e[63:32]);
        chk("wrap_out_inst", ifw.out_inst, e[31:0]);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    en_w = 1'b0;
    redirect_valid = 1'b0;
    ifc.out_ready = 1'b1;
    ifw.out_ready = 1'b1;
    exp_q.delete();
    exp_qw.delete();
    step(2);
    chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_out_inst", ifc.out_inst, 32'd0);
    chk("rst_out_pc", ifc.out_pc, 32'd0);
    chk("rst_fifo_count", {30'b0, fifo_count}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_rom_addr", ifc.rom_addr, 32'd0);
    chk("rst_wrap_rom_addr", ifw.rom_addr, 32'h3FFF_FFFE);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    ifc.out_ready = 1'b1;
    ifw.out_ready = 1'b1;

    // 1: streaming at one instruction per cycle
    do_reset();
    push(32'h0, 32'hC0DE_0000);
    push(32'h4, 32'hC0DE_0004);
    push(32'h8, 32'hC0DE_0008);
    push(32'hC, 32'hC0DE_000C);
    en = 1'b1;
    step(1);
    chk("t1_first_valid", {31'b0, ifc.out_valid}, 32'd1);
    chk("t1_first_pc", ifc.out_pc, 32'h0);
    chk("t1_count", {30'b0, fifo_count}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t1_no_gap", {31'b0, ifc.out_valid}, 32'd1);
    end
    en = 1'b0;
    step(2);
    chk("t1_drained", exp_q.size(), 32'd0);
    chk("t1_empty_valid", {31'b0, ifc.out_valid}, 32'd0);

    // 2: backpressure fills and holds the FIFO
    do_reset();
    push(32'h0, 32'hC0DE_0000);
    push(32'h4, 32'hC0DE_0004);
    push(32'h8, 32'hC0DE_0008);
    ifc.out_ready = 1'b0;
    en = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t2_full_count", {30'b0, fifo_count}, 32'd2);
    end
    chk("t2_rom_addr_hold", ifc.rom_addr, 32'd2);
    ifc.out_ready = 1'b1;
    step(1);
    chk("t2_push_pop_count", {30'b0, fifo_count}, 32'd2);
    en = 1'b0;
    step(3);
    chk("t2_drained", exp_q.size(), 32'd0);
    chk("t2_count_zero", {30'b0, fifo_count}, 32'd0);

    // 3: redirect flushes a full FIFO
    do_reset();
    ifc.out_ready = 1'b0;
    en = 1'b1;
    step(2);
    chk("t3_full", {30'b0, fifo_count}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step(1);
    chk("t3_flush_count", {30'b0, fifo_count}, 32'd0);
    chk("t3_flush_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("t3_rom_addr", ifc.rom_addr, 32'h40);
    redirect_valid = 1'b0;
    ifc.out_ready = 1'b1;
    push(32'h100, 32'hC0DE_0100);
    step(1);
    chk("t3_head_pc", ifc.out_pc, 32'h100);
    en = 1'b0;
    step(2);
    chk("t3_drained", exp_q.size(), 32'd0);

    // 4: halt opcode stops fetch until redirect
    do_reset();
    halt_mode = 1'b1;
    push(32'h0, 32'hC0DE_0000);
    push(32'h4, 32'hC0DE_0004);
    push(32'h8, 32'hFFFF_FFFF);
    en = 1'b1;
    step(3);
    chk("t4_halted", {31'b0, halted}, 32'd1);
    step(2);
    chk("t4_rom_addr_frozen", ifc.rom_addr, 32'd3);
    chk("t4_count", {30'b0, fifo_count}, 32'd0);
    chk("t4_drained", exp_q.size(), 32'd0);
    chk("t4_still_halted", {31'b0, halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step(1);
    chk("t4_unhalted", {31'b0, halted}, 32'd0);
    chk("t4_resume_addr", ifc.rom_addr, 32'h8);
    redirect_valid = 1'b0;
    push(32'h20, 32'hC0DE_0020);
    push(32'h24, 32'hC0DE_0024);
    step(2);
    en = 1'b0;
    step(2);
    chk("t4_resume_drained", exp_q.size(), 32'd0);
    halt_mode = 1'b0;

    // 5: PC wrap-around from the top of the address space
    do_reset();
    exp_qw.push_back({32'hFFFF_FFF8, 32'hC0DE_FFF8});
    exp_qw.push_back({32'hFFFF_FFFC, 32'hC0DE_FFFC});
    exp_qw.push_back({32'h0000_0000, 32'hC0DE_0000});
    en_w = 1'b1;
    step(3);
    en_w = 1'b0;
    step(2);
    chk("t5_drained", exp_qw.size(), 32'd0);
    chk("t5_rom_addr", ifw.rom_addr, 32'd1);

    // 6: async reset mid-stream discards queued entries
    do_reset();
    ifc.out_ready = 1'b0;
    en = 1'b1;
    step(2);
    chk("t6_queued", {30'b0, fifo_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("t6_async_count", {30'b0, fifo_count}, 32'd0);
    chk("t6_async_rom_addr", ifc.rom_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    push(32'h0, 32'hC0DE_0000);
    push(32'h4, 32'hC0DE_0004);
    step(2);
    en = 1'b0;
    step(2);
    chk("t6_drained", exp_q.size(), 32'd0);
    chk("t6_rom_addr", ifc.rom_addr, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
